rgb_timing_checker: RTL and testbench

- Receive-side counterpart of the RGB source. It samples a parallel RGB stream (VSA, HSA, DE, 8-bit R/G/B) and measures per-frame timing: active pixels per line, active lines, line period and lines per frame.
- It checks the measurements against expected geometry, accumulates a pixel checksum, and publishes results once per frame.
- It sits at a panel-side tap or in the loopback testbench, on the same Sys_Clock as the pixel stream.

---
 rtl/rgb_timing_checker.sv | 205 ++++++++++++++++++++
 tb/tb_rgb_timing_checker.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_timing_checker.sv
// rgb_timing_checker: measures per-frame RGB stream geometry and pixel checksum,
// publishing results two cycles after the closing VSA edge is sampled.
module rgb_timing_checker #(
   parameter int EXP_H_ACTIVE = 800,
   parameter int EXP_V_ACTIVE = 480
) (
   input  logic        Sys_Clock,
   input  logic        Reset,
   input  logic        VSA,
   input  logic        HSA,
   input  logic        DE,
   input  logic [7:0]  R,
   input  logic [7:0]  G,
   input  logic [7:0]  B,
   output logic [15:0] Meas_H_Active,
   output logic [15:0] Meas_V_Active,
   output logic [15:0] Meas_H_Total,
   output logic [15:0] Meas_V_Total,
   output logic [31:0] Pix_Sum,
   output logic [15:0] Frame_Cnt,
   output logic        Frame_Done,
   output logic        Frame_Err
);
   localparam logic [15:0] MAX   = 16'hFFFF;
   localparam logic [15:0] EXP_H = 16'(EXP_H_ACTIVE);
   localparam logic [15:0] EXP_V = 16'(EXP_V_ACTIVE);

   typedef enum logic {WAIT_VS, MEASURE} state_t;
   state_t state, state_nx;
   logic   clear, run, close;

   logic        vsa_d1, vsa_d2, hsa_d1, hsa_d2, de_d1, de_d2;
   logic [23:0] rgb_d1;
   logic        vs_rise, hs_rise, de_fall, first_line;

   logic [15:0] h_clk, h_tot, v_tot, de_cnt, v_act, line_ref;
   logic        line_mis, sat;
   logic [31:0] line_sum, sum;

   logic [15:0] h_clk_nx, v_tot_nx, de_cnt_nx, v_act_nx, line_ref_nx;
   logic        line_mis_nx, sat_nx, frame_err;
   logic [31:0] line_sum_nx, sum_nx;

   logic        snap_v, snap_err;
   logic [15:0] snap_h_act, snap_v_act, snap_h_tot, snap_v_tot;
   logic [31:0] snap_sum;

   always_ff @(posedge Sys_Clock or posedge Reset) begin
      if (Reset) begin
         vsa_d1 <= 1'b0;
         vsa_d2 <= 1'b0;
         hsa_d1 <= 1'b0;
         hsa_d2 <= 1'b0;
         de_d1  <= 1'b0;
         de_d2  <= 1'b0;
         rgb_d1 <= '0;
      end else begin
         vsa_d1 <= VSA;
         vsa_d2 <= vsa_d1;
         hsa_d1 <= HSA;
         hsa_d2 <= hsa_d1;
         de_d1  <= DE;
         de_d2  <= de_d1;
         rgb_d1 <= {R, G, B};
      end
   end

   assign vs_rise = vsa_d1 & ~vsa_d2;
   assign hs_rise = hsa_d1 & ~hsa_d2;
   assign de_fall = ~de_d1 & de_d2;

   always_ff @(posedge Sys_Clock or posedge Reset) begin
      if (Reset) state <= WAIT_VS;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      clear    = 1'b0;
      run      = 1'b0;
      close    = 1'b0;
      unique case (state)
         WAIT_VS: begin
            if (vs_rise) begin
               state_nx = MEASURE;
               clear    = 1'b1;
            end
         end
         MEASURE: begin
            run   = 1'b1;
            clear = vs_rise;
            close = vs_rise;
         end
      endcase
   end

   // Next values include this cycle's events, so a DE fall that lands on
   // the closing VSA edge is still credited to the closing frame.
   always_comb begin
      first_line  = (v_act == '0);
      h_clk_nx    = hs_rise ? 16'd1 :
                    (h_clk == MAX) ? h_clk : h_clk + 16'd1;
      v_tot_nx    = (hs_rise && v_tot != MAX) ? v_tot + 16'd1 : v_tot;
      v_act_nx    = (de_fall && v_act != MAX) ? v_act + 16'd1 : v_act;
      de_cnt_nx   = de_fall ? '0 :
                    (de_d1 && de_cnt != MAX) ? de_cnt + 16'd1 : de_cnt;
      line_ref_nx = (de_fall && first_line) ? de_cnt : line_ref;
      line_mis_nx = line_mis |
                    (de_fall & ~first_line & (de_cnt != line_ref));
      sat_nx      = sat |
                    (~hs_rise & (h_clk == MAX)) |
                    (de_d1 & (de_cnt == MAX)) |
                    (de_fall & (v_act == MAX)) |
                    (hs_rise & (v_tot == MAX));
      line_sum_nx = de_fall ? '0 :
                    de_d1 ? line_sum + {8'd0, rgb_d1} : line_sum;
      sum_nx      = de_fall ? sum + line_sum : sum;
      frame_err   = (line_ref_nx != EXP_H) | (v_act_nx != EXP_V) |
                    line_mis_nx | de_d1 | sat_nx;
   end

   always_ff @(posedge Sys_Clock or posedge Reset) begin
      if (Reset) begin
         h_clk    <= '0;
         h_tot    <= '0;
         v_tot    <= '0;
         de_cnt   <= '0;
         v_act    <= '0;
         line_ref <= '0;
         line_mis <= 1'b0;
         sat      <= 1'b0;
         line_sum <= '0;
         sum      <= '0;
      end else if (clear) begin
         h_clk    <= 16'd1;
         h_tot    <= '0;
         v_tot    <= hs_rise ? 16'd1 : 16'd0;
         de_cnt   <= '0;
         v_act    <= '0;
         line_ref <= '0;
         line_mis <= 1'b0;
         sat      <= 1'b0;
         line_sum <= '0;
         sum      <= '0;
      end else if (run) begin
         h_clk    <= h_clk_nx;
         if (hs_rise) h_tot <= h_clk;
         v_tot    <= v_tot_nx;
         de_cnt   <= de_cnt_nx;
         v_act    <= v_act_nx;
         line_ref <= line_ref_nx;
         line_mis <= line_mis_nx;
         sat      <= sat_nx;
         line_sum <= line_sum_nx;
         sum      <= sum_nx;
      end
   end

   // Results pass through one snapshot stage before reaching the outputs.
   always_ff @(posedge Sys_Clock or posedge Reset) begin
      if (Reset) begin
         snap_v     <= 1'b0;
         snap_err   <= 1'b0;
         snap_h_act <= '0;
         snap_v_act <= '0;
         snap_h_tot <= '0;
         snap_v_tot <= '0;
         snap_sum   <= '0;
      end else begin
         snap_v <= close;
         if (close) begin
            snap_err   <= frame_err;
            snap_h_act <= line_ref_nx;
            snap_v_act <= v_act_nx;
            snap_h_tot <= h_tot;
            snap_v_tot <= v_tot;
            snap_sum   <= sum_nx;
         end
      end
   end

   always_ff @(posedge Sys_Clock or posedge Reset) begin
      if (Reset) begin
         Meas_H_Active <= '0;
         Meas_V_Active <= '0;
         Meas_H_Total  <= '0;
         Meas_V_Total  <= '0;
         Pix_Sum       <= '0;
         Frame_Cnt     <= '0;
         Frame_Done    <= 1'b0;
         Frame_Err     <= 1'b0;
      end else begin
         Frame_Done <= snap_v;
         if (snap_v) begin
            Meas_H_Active <= snap_h_act;
            Meas_V_Active <= snap_v_act;
            Meas_H_Total  <= snap_h_tot;
            Meas_V_Total  <= snap_v_tot;
            Pix_Sum       <= snap_sum;
            Frame_Err     <= snap_err;
            if (Frame_Cnt != MAX) Frame_Cnt <= Frame_Cnt + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_rgb_timing_checker.sv
// tb_rgb_timing_checker: directed and random RGB frames, checked each cycle
// against a frame-level model computed from the recorded input stream.
module tb_rgb_timing_checker;
   localparam int EH = 8;
   localparam int EV = 6;
   localparam int HN = 16384;

   logic        clk = 1'b0;
   logic        Reset;
   logic        VSA, HSA, DE;
   logic [7:0]  R, G, B;
   logic [15:0] Meas_H_Active, Meas_V_Active, Meas_H_Total, Meas_V_Total;
   logic [15:0] Frame_Cnt;
   logic [31:0] Pix_Sum;
   logic        Frame_Done, Frame_Err;

   rgb_timing_checker #(.EXP_H_ACTIVE(EH), .EXP_V_ACTIVE(EV)) dut (
      .Sys_Clock(clk), .Reset(Reset), .VSA(VSA), .HSA(HSA), .DE(DE),
      .R(R), .G(G), .B(B),
      .Meas_H_Active(Meas_H_Active), .Meas_V_Active(Meas_V_Active),
      .Meas_H_Total(Meas_H_Total), .Meas_V_Total(Meas_V_Total),
      .Pix_Sum(Pix_Sum), .Frame_Cnt(Frame_Cnt),
      .Frame_Done(Frame_Done), .Frame_Err(Frame_Err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int      h_act;
      int      v_act;
      int      h_tot;
      int      v_tot;
      bit [31:0] sum;
      bit      err;
      int      due;
   } exp_t;

   bit        hv[HN];
   bit        hh[HN];
   bit        hd[HN];
   bit [23:0] hp[HN];
   exp_t      q[$];
   exp_t      cur;
   int        n = 0;
   int        cnt = 0;
   int        frame_start = -1;
   int        last_vs = 0;
   int        last_done_n = -1;
   int        total = 0;
   int        bad = 0;
   bit        e_done;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, n);
      end
   endtask

   // A frame spans VSA rise s (inclusive) to next VSA rise e (exclusive for
   // HSA, inclusive for DE falls); its counting starts on the cycle after s.
   function automatic exp_t calc(int s, int e);
      exp_t x;
      int   rises[$];
      int   nl, len;
      bit   mis, open;
      x.h_act = 0; x.h_tot = 0; x.sum = '0; nl = 0; mis = 0;
      for (int i = s; i < e; i++)
         if (hh[i] && !hh[i-1]) rises.push_back(i);
      x.v_tot = rises.size();
      if (rises.size() >= 2) x.h_tot = rises[$] - rises[$-1];
      else if (rises.size() == 1 && rises[0] > s) x.h_tot = rises[0] - s;
      for (int f = s + 1; f <= e; f++) begin
         if (!hd[f] && hd[f-1]) begin
            len = 0;
            for (int j = f - 1; j > s && hd[j]; j--) len++;
            if (nl == 0) x.h_act = len;
            else if (len != x.h_act) mis = 1;
            nl++;
         end
      end
      x.v_act = nl;
      open = hd[e];
      for (int i = e - 1; i > s; i--) begin
         if (!hd[i]) open = 0;
         else if (!open) x.sum += 32'(hp[i]);
      end
      x.err = (x.h_act != EH) || (nl != EV) || mis || hd[e];
      x.due = e + 2;
      return x;
   endfunction

   task automatic model_reset();
      q.delete();
      frame_start = -1;
      cur.h_act = 0; cur.v_act = 0; cur.h_tot = 0; cur.v_tot = 0;
      cur.sum = '0; cur.err = 0; cur.due = 0;
      cnt = 0;
   endtask

   task automatic drive(bit v, bit h, bit d, bit [23:0] px);
      int i;
      @(negedge clk);
      VSA = v; HSA = h; DE = d; {R, G, B} = px;
      i = n + 1;
      if (i >= HN) begin
         $display("FAIL history: index %0d out of range", i);
         $fatal(1);
      end
      hv[i] = v; hh[i] = h; hd[i] = d; hp[i] = px;
      if (v && !hv[i-1]) begin
         if (frame_start >= 0) q.push_back(calc(frame_start, i));
         frame_start = i;
         last_vs = i;
      end
   endtask

   task automatic idle(int k);
      repeat (k) drive(1'b0, 1'b0, 1'b0, 24'd0);
   endtask

   // mode 0 solid red, 1 incrementing index, 2 random pixels
   task automatic gen_frame(int ha, int va, int ht, int vt, int short_ln,
                            int mode, bit head, bit tail, int stop);
      int        p, len;
      bit        d;
      bit [7:0]  b8;
      bit [23:0] px;
      p = 0;
      for (int l = 0; l < vt; l++) begin
         if (l == stop) return;
         for (int c = 0; c < ht; c++) begin
            len = (l - 1 == short_ln) ? ha - 1 : ha;
            d = (l >= 1) && (l <= va) && (c >= 2) && (c < 2 + len);
            if (head && l == 0 && c < 2) d = 1;
            if (tail && l == vt - 1 && c >= ht - 3) d = 1;
            px = 24'($urandom);
            if (d) begin
               b8 = 8'(p);
               if (mode == 0) px = 24'hFF0000;
               else if (mode == 1) px = {b8, b8, b8};
               p++;
            end
            drive(l == 0, c < 2, d, px);
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         n++;
         e_done = 1'b0;
         if (q.size() > 0 && q[0].due == n) begin
            cur = q.pop_front();
            e_done = 1'b1;
            if (cnt < 65535) cnt++;
         end
         if (Frame_Done === 1'b1) last_done_n = n;
         chk("done", 32'(Frame_Done), 32'(e_done));
         chk("h_act", 32'(Meas_H_Active), 32'(cur.h_act));
         chk("v_act", 32'(Meas_V_Active), 32'(cur.v_act));
         chk("h_tot", 32'(Meas_H_Total), 32'(cur.h_tot));
         chk("v_tot", 32'(Meas_V_Total), 32'(cur.v_tot));
         chk("pix_sum", Pix_Sum, cur.sum);
         chk("err", 32'(Frame_Err), 32'(cur.err));
         chk("frame_cnt", 32'(Frame_Cnt), 32'(cnt));
      end
   end

   initial begin
      int  ha, va, ht, vt, sl;
      bit  tl, hd_prev;
      Reset = 1'b1;
      VSA = 0; HSA = 0; DE = 0; R = 0; G = 0; B = 0;
      model_reset();
      idle(3);
      chk("rst_done", 32'(Frame_Done), 32'd0);
      chk("rst_cnt", 32'(Frame_Cnt), 32'd0);
      chk("rst_sum", Pix_Sum, 32'd0);
      chk("rst_hact", 32'(Meas_H_Active), 32'd0);
      Reset = 1'b0;
      idle(5);

      repeat (3) gen_frame(EH, EV, 12, 9, -1, 0, 0, 0, -1);
      chk("solid_hact", 32'(Meas_H_Active), 32'd8);
      chk("solid_vact", 32'(Meas_V_Active), 32'd6);
      chk("solid_htot", 32'(Meas_H_Total), 32'd12);
      chk("solid_vtot", 32'(Meas_V_Total), 32'd9);
      chk("solid_sum", Pix_Sum, 32'h2FD00000);
      chk("solid_err", 32'(Frame_Err), 32'd0);
      chk("solid_cnt", 32'(Frame_Cnt), 32'd2);

      gen_frame(EH, EV, 12, 9, 2, 0, 0, 0, -1);
      gen_frame(EH, EV, 12, 9, -1, 0, 0, 0, -1);
      chk("short_err", 32'(Frame_Err), 32'd1);
      chk("short_hact", 32'(Meas_H_Active), 32'd8);
      chk("short_vact", 32'(Meas_V_Active), 32'd6);

      gen_frame(EH, EV - 1, 12, 9, -1, 0, 0, 0, -1);
      gen_frame(EH, EV, 12, 9, -1, 0, 0, 0, -1);
      chk("few_vact", 32'(Meas_V_Active), 32'd5);
      chk("few_err", 32'(Frame_Err), 32'd1);
      gen_frame(EH, EV, 12, 9, -1, 0, 0, 0, -1);
      chk("recover_err", 32'(Frame_Err), 32'd0);

      gen_frame(EH, EV, 12, 9, -1, 0, 0, 1, -1);
      gen_frame(EH, EV, 12, 9, -1, 0, 1, 0, -1);
      chk("open_vact", 32'(Meas_V_Active), 32'd6);
      chk("open_sum", Pix_Sum, 32'h2FD00000);
      chk("open_err", 32'(Frame_Err), 32'd1);
      gen_frame(EH, EV, 12, 9, -1, 0, 0, 0, -1);

      gen_frame(EH, EV, 12, 9, -1, 0, 0, 0, 4);
      #2;
      Reset = 1'b1;
      model_reset();
      #1;
      chk("midrst_hact", 32'(Meas_H_Active), 32'd0);
      chk("midrst_cnt", 32'(Frame_Cnt), 32'd0);
      chk("midrst_sum", Pix_Sum, 32'd0);
      idle(3);
      Reset = 1'b0;
      idle(4);
      gen_frame(EH, EV, 12, 9, -1, 0, 0, 0, -1);
      gen_frame(EH, EV, 12, 9, -1, 0, 0, 0, -1);
      chk("post_cnt", 32'(Frame_Cnt), 32'd1);
      chk("post_hact", 32'(Meas_H_Active), 32'd8);
      chk("post_err", 32'(Frame_Err), 32'd0);

      gen_frame(4, 2, 8, 4, -1, 1, 0, 0, -1);
      gen_frame(4, 2, 8, 4, -1, 0, 0, 0, -1);
      chk("inc_sum", Pix_Sum, 32'h001C1C1C);
      chk("inc_hact", 32'(Meas_H_Active), 32'd4);
      chk("inc_htot", 32'(Meas_H_Total), 32'd8);
      chk("inc_vtot", 32'(Meas_V_Total), 32'd4);
      chk("latency", 32'(last_done_n), 32'(last_vs + 2));

      hd_prev = 0;
      repeat (10) begin
         ha = $urandom_range(1, 6);
         va = $urandom_range(1, 4);
         ht = ha + 3 + $urandom_range(0, 3);
         vt = va + 2 + $urandom_range(0, 2);
         sl = ($urandom_range(0, 2) == 0) ? $urandom_range(0, va - 1) : -1;
         tl = ($urandom_range(0, 2) == 0);
         gen_frame(ha, va, ht, vt, sl, 2,
                   hd_prev && ($urandom_range(0, 1) == 1), tl, -1);
         hd_prev = tl;
      end
      gen_frame(EH, EV, 12, 9, -1, 2, hd_prev, 0, -1);
      idle(5);
      if (q.size() != 0) begin
         bad++;
         total++;
         $display("FAIL pending: %0d frames never reported", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
